// File: rtl/mc_pkg.sv
// Shared constants and types for the MC read streamer.
package mc_pkg;

    localparam logic [2:0] MC_CMD_RD     = 3'd1;
    localparam logic [2:0] MC_CMD_RDDATA = 3'd2;
    localparam logic [1:0] MC_SIZE_8B    = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Byte address of element idx: base + 8*idx, wrapping modulo 2^48.
    function automatic logic [47:0] elem_addr(input logic [47:0] base, input logic [31:0] idx);
        logic [44:0] qword;
        qword = base[47:3] + {13'd0, idx};
        return {qword, 3'b000};
    endfunction

endpackage

// File: rtl/mc_read_streamer_fifo.sv
// Synchronous first-word-fall-through FIFO holding {tag, data} responses.
module fifo_sync #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] rd_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_pop;
    logic             full;

    assign valid   = (count_q != '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & valid;
    assign rd_data = mem_q[rd_ptr_q];

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(do_pop);
    end

    // Pointer/occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Credits bound outstanding reads to DEPTH, so a push into a full FIFO is a design bug.
    always_ff @(posedge clk) begin
        if (!i_reset) begin
            assert (!(push && full));
        end
    end

endmodule

// File: rtl/mc_read_streamer.sv
// Issues 8-byte MC reads for a (base, count) job and streams responses out.
//
//  state | meaning
//  IDLE  | waiting for start; stray responses are dropped
//  ISSUE | sending reads while credits and elements remain
//  DRAIN | all reads sent; waiting for every element to leave on out_*
//  DONE  | one cycle; raises done on the way back to IDLE
module mc_read_streamer
    import mc_pkg::*;
#(
    parameter int RTNCTL_WIDTH    = 32,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                    clk,
    input  logic                    i_reset,
    input  logic                    start,
    input  logic [47:0]             base_addr,
    input  logic [31:0]             elem_count,
    output logic                    busy,
    output logic                    done,
    output logic                    mc_rq_vld,
    output logic [2:0]              mc_rq_cmd,
    output logic [3:0]              mc_rq_scmd,
    output logic [1:0]              mc_rq_size,
    output logic [47:0]             mc_rq_vadr,
    output logic [RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
    output logic [63:0]             mc_rq_data,
    input  logic                    mc_rq_stall,
    input  logic                    mc_rs_vld,
    input  logic [2:0]              mc_rs_cmd,
    input  logic [3:0]              mc_rs_scmd,
    input  logic [63:0]             mc_rs_data,
    input  logic [RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
    output logic                    mc_rs_stall,
    output logic                    mc_rq_flush,
    input  logic                    mc_rs_flush_cmplt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [63:0]             out_data,
    output logic [31:0]             out_tag
);

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    state_e                  state_q, state_d;
    logic [47:0]             base_q, base_d;
    logic [31:0]             count_q, count_d;
    logic [31:0]             idx_q, idx_d;
    logic [31:0]             popped_q, popped_d;
    logic [CW-1:0]           credits_q, credits_d;
    logic                    req_pend_q, req_pend_d;
    logic [47:0]             req_vadr_q, req_vadr_d;
    logic [RTNCTL_WIDTH-1:0] req_rtnctl_q, req_rtnctl_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    send;
    logic                    push;
    logic                    pop;
    logic                    fifo_valid;
    logic [95:0]             fifo_rd;
    logic                    unused_inputs;

    // A prepared request goes out only in a cycle the MC is not stalling.
    assign send = req_pend_q & ~mc_rq_stall;
    assign push = mc_rs_vld & (mc_rs_cmd == MC_CMD_RDDATA) & (state_q != IDLE);
    assign pop  = fifo_valid & out_ready;

    assign unused_inputs = ^{mc_rs_scmd, mc_rs_flush_cmplt};

    // Next-state, counters and the prepared request for the following cycle.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        count_d      = count_q;
        idx_d        = idx_q + 32'(send);
        popped_d     = popped_q + 32'(pop);
        credits_d    = credits_q - CW'(send) + CW'(pop);
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    base_d   = {base_addr[47:3], 3'b000};
                    count_d  = elem_count;
                    idx_d    = '0;
                    popped_d = '0;
                    state_d  = (elem_count == 32'd0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (idx_d == count_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (popped_q == count_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        busy_d       = (state_d != IDLE) | done_d;
        req_pend_d   = (state_d == ISSUE) && (idx_d < count_d) && (credits_d != '0);
        req_vadr_d   = elem_addr(base_d, idx_d);
        req_rtnctl_d = RTNCTL_WIDTH'(idx_d);
    end

    // Single register stage for the FSM, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            base_q       <= '0;
            count_q      <= '0;
            idx_q        <= '0;
            popped_q     <= '0;
            credits_q    <= CW'(MAX_OUTSTANDING);
            req_pend_q   <= 1'b0;
            req_vadr_q   <= '0;
            req_rtnctl_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            popped_q     <= popped_d;
            credits_q    <= credits_d;
            req_pend_q   <= req_pend_d;
            req_vadr_q   <= req_vadr_d;
            req_rtnctl_q <= req_rtnctl_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    fifo_sync #(
        .WIDTH (96),
        .DEPTH (MAX_OUTSTANDING)
    ) u_rsp_fifo (
        .clk       (clk),
        .i_reset   (i_reset),
        .push      (push),
        .push_data ({32'(mc_rs_rtnctl), mc_rs_data}),
        .pop       (pop),
        .valid     (fifo_valid),
        .rd_data   (fifo_rd)
    );

    assign busy         = busy_q;
    assign done         = done_q;
    assign mc_rq_vld    = send;
    assign mc_rq_cmd    = send ? MC_CMD_RD : 3'd0;
    assign mc_rq_scmd   = 4'd0;
    assign mc_rq_size   = send ? MC_SIZE_8B : 2'd0;
    assign mc_rq_vadr   = req_vadr_q;
    assign mc_rq_rtnctl = req_rtnctl_q;
    assign mc_rq_data   = 64'd0;
    assign mc_rs_stall  = 1'b0;
    assign mc_rq_flush  = 1'b0;
    assign out_valid    = fifo_valid;
    assign out_data     = fifo_rd[63:0];
    assign out_tag      = fifo_rd[95:64];

endmodule

// File: tb/tb_mc_read_streamer.sv
// Directed and randomized bench for mc_read_streamer with an MC/sink model.
module tb_mc_read_streamer;
    import mc_pkg::*;

    localparam int RW = 32;
    localparam int MO = 16;

    typedef struct packed {
        logic [47:0] addr;
        logic [31:0] tag;
    } req_t;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          start = 1'b0;
    logic [47:0]   base_addr = '0;
    logic [31:0]   elem_count = '0;
    logic          busy, done;
    logic          mc_rq_vld;
    logic [2:0]    mc_rq_cmd;
    logic [3:0]    mc_rq_scmd;
    logic [1:0]    mc_rq_size;
    logic [47:0]   mc_rq_vadr;
    logic [RW-1:0] mc_rq_rtnctl;
    logic [63:0]   mc_rq_data;
    logic          mc_rq_stall = 1'b0;
    logic          mc_rs_vld = 1'b0;
    logic [2:0]    mc_rs_cmd = '0;
    logic [3:0]    mc_rs_scmd = '0;
    logic [63:0]   mc_rs_data = '0;
    logic [RW-1:0] mc_rs_rtnctl = '0;
    logic          mc_rs_stall;
    logic          mc_rq_flush;
    logic          mc_rs_flush_cmplt = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [63:0]   out_data;
    logic [31:0]   out_tag;

    // Bench state
    int unsigned   n_cmp = 0;
    int unsigned   n_err = 0;
    int            stall_mode = 0;   // 0 never, 1 toggle, 2 random
    int            ready_mode = 0;   // 0 always ready, 1 never, 2 random
    int            rs_mode = 0;      // 0 in order, 1 withhold, 2 reverse, 3 random, 4 flush
    int            job_id = 0;
    logic [47:0]   job_base = '0;
    logic [31:0]   job_count = '0;
    int unsigned   req_cnt = 0, out_cnt = 0, done_cnt = 0;
    int unsigned   job_req0 = 0, job_out0 = 0, job_done0 = 0;
    int unsigned   rq_idx;
    int            rs_k;
    req_t          rs_r;
    req_t          pend[$];
    logic [47:0]   rq_log[$];
    logic [31:0]   out_log[$];
    int            seen[logic [31:0]];

    mc_read_streamer #(.RTNCTL_WIDTH(RW), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .i_reset(i_reset), .start(start), .base_addr(base_addr),
        .elem_count(elem_count), .busy(busy), .done(done),
        .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
        .mc_rq_size(mc_rq_size), .mc_rq_vadr(mc_rq_vadr), .mc_rq_rtnctl(mc_rq_rtnctl),
        .mc_rq_data(mc_rq_data), .mc_rq_stall(mc_rq_stall),
        .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd),
        .mc_rs_data(mc_rs_data), .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_stall(mc_rs_stall),
        .mc_rq_flush(mc_rq_flush), .mc_rs_flush_cmplt(mc_rs_flush_cmplt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // Memory contents as seen by the MC model: a fixed function of the address.
    function automatic logic [63:0] data_of(input logic [47:0] a);
        return {a[15:0] ^ 16'hA5C3, a};
    endfunction

    function automatic logic [47:0] addr_of(input logic [47:0] b, input logic [31:0] i);
        return b + 48'(i) * 48'd8;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // MC and sink model: drives stall, ready and responses just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (stall_mode)
            0:       mc_rq_stall = 1'b0;
            1:       mc_rq_stall = ~mc_rq_stall;
            default: mc_rq_stall = ($urandom_range(0, 2) == 0);
        endcase
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 1) == 1);
        endcase
        mc_rs_vld = 1'b0; mc_rs_cmd = '0; mc_rs_data = '0; mc_rs_rtnctl = '0;
        rs_k = -1;
        if (rs_mode == 4) begin
            pend.delete();
        end else if (pend.size() > 0) begin
            case (rs_mode)
                0: rs_k = 0;
                2: rs_k = pend.size() - 1;
                3: if ($urandom_range(0, 3) != 0) rs_k = int'($urandom_range(0, pend.size() - 1));
                default: rs_k = -1;
            endcase
        end
        if (rs_k >= 0) begin
            rs_r = pend[rs_k];
            pend.delete(rs_k);
            mc_rs_vld = 1'b1; mc_rs_cmd = MC_CMD_RDDATA;
            mc_rs_data = data_of(rs_r.addr); mc_rs_rtnctl = RW'(rs_r.tag);
        end else if (rs_mode == 3 && $urandom_range(0, 4) == 0) begin
            mc_rs_vld = 1'b1;
            mc_rs_cmd = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd4;
            mc_rs_data = {$urandom, $urandom};
            mc_rs_rtnctl = RW'($urandom);
        end
    end

    // Monitor: checks every request and every element leaving, away from the active edge.
    always @(negedge clk) begin
        if (!i_reset) begin
            if (mc_rq_vld) begin
                rq_idx = req_cnt - job_req0;
                chk("rq_no_stall", 64'(mc_rq_stall), 64'd0);
                chk("rq_cmd", 64'(mc_rq_cmd), 64'(MC_CMD_RD));
                chk("rq_size", 64'(mc_rq_size), 64'(MC_SIZE_8B));
                chk("rq_vadr", 64'(mc_rq_vadr), 64'(addr_of(job_base, rq_idx)));
                chk("rq_rtnctl", 64'(mc_rq_rtnctl), 64'(rq_idx));
                chk("rq_in_range", 64'(rq_idx < job_count), 64'd1);
                chk("rq_credit", 64'((rq_idx - (out_cnt - job_out0)) < MO), 64'd1);
                pend.push_back('{addr: mc_rq_vadr, tag: 32'(mc_rq_rtnctl)});
                rq_log.push_back(mc_rq_vadr);
                req_cnt++;
            end
            if (mc_rs_vld) chk("rs_stall", 64'(mc_rs_stall), 64'd0);
            if (out_valid && out_ready) begin
                chk("out_tag_range", 64'(out_tag < job_count), 64'd1);
                chk("out_data", out_data, data_of(addr_of(job_base, out_tag)));
                chk("out_dup", 64'(seen.exists(out_tag) && seen[out_tag] == job_id), 64'd0);
                seen[out_tag] = job_id;
                out_log.push_back(out_tag);
                out_cnt++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [47:0] b, input logic [31:0] c);
        job_id++;
        job_base  = {b[47:3], 3'b000};
        job_count = c;
        job_req0  = req_cnt;
        job_out0  = out_cnt;
        job_done0 = done_cnt;
        base_addr = b; elem_count = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_reqs(input int unsigned n, input int budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (req_cnt - job_req0 >= n) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk(name, 64'(ok), 64'd1);
    endtask

    task automatic finish_job(input int budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (!busy) begin ok = 1'b1; break; end
        end
        chk({name, "_timeout"}, 64'(ok), 64'd1);
        chk({name, "_reqs"}, 64'(req_cnt - job_req0), 64'(job_count));
        chk({name, "_outs"}, 64'(out_cnt - job_out0), 64'(job_count));
        chk({name, "_done_once"}, 64'(done_cnt - job_done0), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] rb;
        logic [31:0] rc;

        // Reset state
        cycles(3);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rq_vld", 64'(mc_rq_vld), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        i_reset = 1'b0;
        cycles(1);

        // 1: four elements, in-order MC, sink always ready; a start while busy is ignored
        start_job(48'h1000, 32'd4);
        cycles(1);
        base_addr = 48'h9000; elem_count = 32'd3; start = 1'b1;
        cycles(1);
        start = 1'b0;
        finish_job(200, "t1");
        for (int i = 0; i < 4; i++) begin
            chk("t1_vadr", 64'(rq_log[job_req0 + i]), 64'(48'h1000 + 48'(8 * i)));
            chk("t1_tag", 64'(out_log[job_out0 + i]), 64'(i));
        end

        // 2: empty job
        start_job(48'h5000, 32'd0);
        chk("t2_busy_c1", 64'(busy), 64'd1);
        chk("t2_done_c1", 64'(done), 64'd0);
        cycles(1);
        chk("t2_busy_c2", 64'(busy), 64'd1);
        chk("t2_done_c2", 64'(done), 64'd1);
        cycles(1);
        chk("t2_busy_c3", 64'(busy), 64'd0);
        chk("t2_done_c3", 64'(done), 64'd0);
        chk("t2_no_reqs", 64'(req_cnt - job_req0), 64'd0);
        chk("t2_done_once", 64'(done_cnt - job_done0), 64'd1);

        // 3: credit limit with responses withheld
        rs_mode = 1;
        start_job(48'h2_0000, 32'd40);
        cycles(60);
        chk("t3_reqs_at_limit", 64'(req_cnt - job_req0), 64'(MO));
        chk("t3_no_out", 64'(out_valid), 64'd0);
        rs_mode = 0;
        finish_job(2000, "t3");

        // 4: request stall toggling every cycle
        stall_mode = 1;
        start_job(48'h4_0000_0040, 32'd8);
        finish_job(500, "t4");
        stall_mode = 0;

        // 5: reverse-order responses held in the FIFO while the sink stalls
        rs_mode = 1; ready_mode = 1;
        start_job(48'h800, 32'd8);
        wait_reqs(8, 200, "t5_all_reqs");
        rs_mode = 2;
        cycles(20);
        chk("t5_out_valid", 64'(out_valid), 64'd1);
        chk("t5_head_tag", 64'(out_tag), 64'd7);
        chk("t5_head_data", out_data, data_of(48'h800 + 48'd56));
        cycles(3);
        chk("t5_head_stable", 64'(out_tag), 64'd7);
        ready_mode = 0;
        finish_job(200, "t5");
        for (int i = 0; i < 8; i++) begin
            chk("t5_order", 64'(out_log[job_out0 + i]), 64'(7 - i));
        end
        rs_mode = 0;

        // 6: address wrap, reset while draining, then a fresh job
        ready_mode = 1;
        start_job(48'hFFFF_FFFF_FFF8, 32'd2);
        wait_reqs(2, 200, "t6_reqs");
        chk("t6_vadr0", 64'(rq_log[job_req0]), 64'h0000_FFFF_FFFF_FFF8);
        chk("t6_vadr1", 64'(rq_log[job_req0 + 1]), 64'd0);
        cycles(6);
        chk("t6_busy_pre", 64'(busy), 64'd1);
        chk("t6_out_valid_pre", 64'(out_valid), 64'd1);
        i_reset = 1'b1;
        cycles(1);
        chk("t6_busy_post", 64'(busy), 64'd0);
        chk("t6_out_valid_post", 64'(out_valid), 64'd0);
        chk("t6_rq_vld_post", 64'(mc_rq_vld), 64'd0);
        i_reset = 1'b0;
        rs_mode = 4;
        cycles(1);
        rs_mode = 0; ready_mode = 0;
        cycles(1);
        start_job(48'h3000, 32'd5);
        finish_job(200, "t6_new");

        // Randomized jobs: random base/count, request stalls, sink stalls, response order
        stall_mode = 2; ready_mode = 2; rs_mode = 3;
        for (int j = 0; j < 6; j++) begin
            rb = {16'($urandom), $urandom};
            rc = 32'($urandom_range(0, 30));
            start_job(rb, rc);
            finish_job(3000, "rnd");
            cycles(2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
